simd_job_arbiter: RTL and testbench

//  Shares one 4-lane SIMD compute unit (start/data_in -> done/data_out) between
//  NUM_REQ requesters. Round-robin grant, one job in flight, start/done sequencing

---
 rtl/simd_job_arbiter.sv | 134 +++++++++++++
 tb/tb_simd_job_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_job_arbiter.sv
// simd_job_arbiter: round-robin sharing of one SIMD compute unit among NUM_REQ requesters.
// Define SIMD_ARB_TIMEOUT_EN to enable the WAIT-state watchdog (aborts with rsp_err=1).
module simd_job_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 32,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [DW-1:0]         rsp_data,
    output logic                  rsp_err,
    output logic                  cu_start,
    output logic [DW-1:0]         cu_data_in,
    input  logic                  cu_done,
    input  logic [DW-1:0]         cu_data_out,
    output logic                  busy,
    output logic [15:0]           jobs_done
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("simd_job_arbiter: unsupported NUM_REQ or TIMEOUT");
    end

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, rsp_id_q, rsp_id_d, gnt_idx;
    logic [DW-1:0]   cu_data_in_q, cu_data_in_d, rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d, gnt_any;
    logic [15:0]     jobs_done_q, jobs_done_d;
`ifdef SIMD_ARB_TIMEOUT_EN
    logic [15:0]     timer_q, timer_d;
`endif

    // Scan from the farthest offset down so the nearest valid requester after rr_ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid[ID_W'((int'(rr_ptr_q) + k) % NUM_REQ)]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign req_ready  = (state_q == IDLE && gnt_any) ? NUM_REQ'(1) << gnt_idx : '0;
    assign rsp_valid  = state_q == RESP;
    assign cu_start   = state_q == ISSUE;
    assign busy       = state_q != IDLE;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign cu_data_in = cu_data_in_q;
    assign jobs_done  = jobs_done_q;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        rsp_id_d     = rsp_id_q;
        cu_data_in_d = cu_data_in_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        jobs_done_d  = jobs_done_q;
`ifdef SIMD_ARB_TIMEOUT_EN
        timer_d      = timer_q;
`endif
        case (state_q)
            IDLE: if (gnt_any) begin
                cu_data_in_d = req_data[gnt_idx*DW +: DW];
                rsp_id_d     = gnt_idx;
                rr_ptr_d     = gnt_idx;
                state_d      = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef SIMD_ARB_TIMEOUT_EN
                timer_d = '0;
`endif
            end
            WAIT: if (cu_done) begin
                rsp_data_d = cu_data_out;
                rsp_err_d  = 1'b0;
                state_d    = RESP;
            end
`ifdef SIMD_ARB_TIMEOUT_EN
            else if (timer_q == 16'(TIMEOUT - 1)) begin
                rsp_data_d = '0;
                rsp_err_d  = 1'b1;
                state_d    = RESP;
            end else begin
                timer_d = timer_q + 16'd1;
            end
`endif
            RESP: if (rsp_ready) begin
                jobs_done_d = jobs_done_q + 16'd1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= ID_W'(NUM_REQ - 1);
            rsp_id_q     <= '0;
            cu_data_in_q <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            jobs_done_q  <= '0;
`ifdef SIMD_ARB_TIMEOUT_EN
            timer_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            rsp_id_q     <= rsp_id_d;
            cu_data_in_q <= cu_data_in_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            jobs_done_q  <= jobs_done_d;
`ifdef SIMD_ARB_TIMEOUT_EN
            timer_q      <= timer_d;
`endif
        end
    end
endmodule

// File: tb/tb_simd_job_arbiter.sv
// tb_simd_job_arbiter: directed table, corner sequences and randomized model check
// for simd_job_arbiter; the compute unit is emulated here and returns operand*8.
module tb_simd_job_arbiter;
    localparam int N = 4, DW = 32, IW = 2, TO = 64;

    logic          clk = 1'b0, reset = 1'b1;
    logic [N-1:0]  req_valid = '0, req_ready;
    logic [N*DW-1:0] req_data = '0;
    logic          rsp_valid, rsp_ready = 1'b1, rsp_err, cu_start, cu_done, busy;
    logic [IW-1:0] rsp_id;
    logic [DW-1:0] rsp_data, cu_data_in, cu_data_out;
    logic [15:0]   jobs_done;

    simd_job_arbiter #(.NUM_REQ(N), .DW(DW), .ID_W(IW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .cu_start(cu_start),
        .cu_data_in(cu_data_in), .cu_done(cu_done), .cu_data_out(cu_data_out),
        .busy(busy), .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, cyc = 0, cu_lat = 1;
    bit cu_rand = 0, cu_hang = 0, spur = 0;
    logic [31:0] spur_data = '0;
    int starts[$];

    typedef struct { logic [3:0] mask; logic [1:0] id; } vec_t;
    typedef struct { logic [1:0] id; logic [31:0] data; } exp_t;
    vec_t tbl[10];
    exp_t q[$];

    initial forever begin @(posedge clk); cyc++; end

    // Compute-unit emulation: done pulse cu_lat cycles after the start pulse.
    initial begin
        int cnt;
        logic [31:0] res;
        cnt = 0; res = '0; cu_done = 1'b0; cu_data_out = '0;
        forever begin
            @(posedge clk); #1;
            cu_done = 1'b0;
            if (reset) cnt = 0;
            else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin cu_done = 1'b1; cu_data_out = res; end
                end
                if (cu_start && !cu_hang) begin
                    cnt = cu_rand ? int'($urandom_range(1, 4)) : cu_lat;
                    res = cu_data_in << 3;
                end
            end
            if (spur) begin cu_done = 1'b1; cu_data_out = spur_data; spur = 0; end
        end
    end

    initial forever begin @(posedge clk); #3; if (cu_start) starts.push_back(cyc); end

    initial begin #500000; $display("FAIL watchdog: simulation time limit reached"); $fatal(1); end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk); #2;
    endtask

    task automatic do_reset;
        reset = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        step; step;
        reset = 1'b0;
    endtask

    task automatic set_lanes(input logic [31:0] base);
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = base + 32'(i);
    endtask

    task automatic run_job(input logic [3:0] mask, output logic [3:0] rdy,
                           output logic [1:0] id, output logic [31:0] d);
        int k;
        req_valid = mask; #1;
        k = 0;
        while (req_ready == '0 && k < 20) begin step; #1; k++; end
        chk("job_grant_bound", k < 20, 1);
        rdy = req_ready;
        step; req_valid = '0; #1;
        k = 0;
        while (!rsp_valid && k < 20) begin step; #1; k++; end
        chk("job_rsp_bound", k < 20, 1);
        id = rsp_id; d = rsp_data;
    endtask

    initial begin
        logic [3:0] rdy;
        logic [1:0] id;
        logic [31:0] d;
        int t0, mn, mx, g_cyc, m_last, g;
        bit m_idle;
        logic [15:0] m_jobs;
        logic [3:0] exp_rdy;
        exp_t e;

        // reset values
        rsp_ready = 1'b1;
        step; step; #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_cu_start", cu_start, 0);
        chk("rst_cu_data_in", cu_data_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_jobs_done", jobs_done, 0);
        reset = 1'b0;

        // single job latency
        step;
        req_data[0 +: DW] = 32'd5; req_valid = 4'b0001; #1;
        chk("t1_grant", req_ready, 4'b0001);
        step; req_valid = '0; #1;
        chk("t1_start", cu_start, 1);
        chk("t1_cu_data_in", cu_data_in, 5);
        chk("t1_ready_low", req_ready, 0);
        chk("t1_busy", busy, 1);
        step; #1;
        chk("t1_start_once", cu_start, 0);
        chk("t1_no_rsp_early", rsp_valid, 0);
        step; #1;
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_data", rsp_data, 40);
        chk("t1_rsp_err", rsp_err, 0);
        step; #1;
        chk("t1_jobs_done", jobs_done, 1);
        chk("t1_idle", busy, 0);

        // round-robin table
        tbl[0] = '{4'b1111, 2'd0}; tbl[1] = '{4'b1111, 2'd1}; tbl[2] = '{4'b1111, 2'd2};
        tbl[3] = '{4'b1111, 2'd3}; tbl[4] = '{4'b1111, 2'd0}; tbl[5] = '{4'b0100, 2'd2};
        tbl[6] = '{4'b1001, 2'd3}; tbl[7] = '{4'b1001, 2'd0}; tbl[8] = '{4'b0010, 2'd1};
        tbl[9] = '{4'b0011, 2'd0};
        do_reset;
        set_lanes(32'd100);
        starts.delete();
        for (int i = 0; i < 10; i++) begin
            run_job(tbl[i].mask, rdy, id, d);
            chk($sformatf("tbl%0d_ready", i), rdy, 4'b0001 << tbl[i].id);
            chk($sformatf("tbl%0d_id", i), id, tbl[i].id);
            chk($sformatf("tbl%0d_data", i), d, (32'd100 + 32'(tbl[i].id)) * 8);
        end
        mn = 1000; mx = 0;
        for (int i = 1; i < starts.size(); i++) begin
            if (starts[i] - starts[i-1] < mn) mn = starts[i] - starts[i-1];
            if (starts[i] - starts[i-1] > mx) mx = starts[i] - starts[i-1];
        end
        chk("tbl_start_count", starts.size(), 10);
        chk("tbl_start_gap_min", mn, 4);
        chk("tbl_start_gap_max", mx, 4);

        // response back-pressure with a spurious done in RESP
        step; step; #1;
        rsp_ready = 1'b0; req_valid = 4'b1111; #1;
        chk("t3_grant", req_ready, 4'b0010);
        step; #1; step; #1; step; #1;
        chk("t3_rsp_valid", rsp_valid, 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin spur_data = 32'hDEAD; spur = 1; end
            step; #1;
            chk("t3_hold_valid", rsp_valid, 1);
            chk("t3_hold_id", rsp_id, 1);
            chk("t3_hold_data", rsp_data, 808);
            chk("t3_hold_ready", req_ready, 0);
            chk("t3_hold_start", cu_start, 0);
        end
        rsp_ready = 1'b1;
        step; #1;
        chk("t3_next_grant", req_ready, 4'b0100);
        chk("t3_jobs_done", jobs_done, 11);
        req_valid = '0;
        step; #1;
        chk("t3_withdrawn", busy, 0);

        // spurious done in IDLE
        spur_data = 32'h1234; spur = 1;
        for (int i = 0; i < 2; i++) begin
            step; #1;
            chk("t4_idle_busy", busy, 0);
            chk("t4_idle_rsp", rsp_valid, 0);
            chk("t4_idle_data", rsp_data, 808);
            chk("t4_idle_jobs", jobs_done, 11);
        end

        // reset while waiting on the unit
        cu_hang = 1;
        req_data[3*DW +: DW] = 32'd9; req_valid = 4'b1000; #1;
        chk("t5_grant", req_ready, 4'b1000);
        step; req_valid = '0; step; step; #1;
        chk("t5_waiting", busy, 1);
        reset = 1'b1;
        step; #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_rsp_valid", rsp_valid, 0);
        chk("t5_rst_cu_data_in", cu_data_in, 0);
        chk("t5_rst_rsp_data", rsp_data, 0);
        chk("t5_rst_rsp_id", rsp_id, 0);
        chk("t5_rst_jobs", jobs_done, 0);
        reset = 1'b0; cu_hang = 0;
        req_data[2*DW +: DW] = 32'd7;
        run_job(4'b0100, rdy, id, d);
        chk("t5_ready", rdy, 4'b0100);
        chk("t5_id", id, 2);
        chk("t5_data", d, 56);
        chk("t5_err", rsp_err, 0);
        step; #1;
        chk("t5_jobs", jobs_done, 1);

        // unit that never completes
        cu_hang = 1;
        req_data[0 +: DW] = 32'd3; req_valid = 4'b0001; #1;
        chk("t6_grant", req_ready, 4'b0001);
        t0 = cyc;
        step; req_valid = '0; #1;
`ifdef SIMD_ARB_TIMEOUT_EN
        while (!rsp_valid && cyc - t0 < 200) begin step; #1; end
        chk("t6_rsp_seen", rsp_valid, 1);
        chk("t6_latency", cyc - t0, 66);
        chk("t6_err", rsp_err, 1);
        chk("t6_data", rsp_data, 0);
        chk("t6_id", rsp_id, 0);
        step; #1;
        chk("t6_jobs", jobs_done, 2);
        chk("t6_idle", busy, 0);
`else
        mn = 0; mx = 0;
        for (int i = 0; i < 100; i++) begin
            step; #1;
            if (rsp_valid) mn++;
            if (!busy) mx++;
        end
        chk("t6_no_rsp", mn, 0);
        chk("t6_busy_held", mx, 0);
        chk("t6_jobs", jobs_done, 1);
`endif
        cu_hang = 0;

        // randomized run against a transaction-level model
        do_reset;
        cu_rand = 1;
        m_idle = 1; m_last = N - 1; m_jobs = '0; g_cyc = -10;
        q.delete();
        for (int c = 0; c < 600; c++) begin
            step;
            req_valid = 4'($urandom);
            for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            g = -1;
            if (m_idle)
                for (int k = 1; k <= N; k++)
                    if (g < 0 && req_valid[(m_last + k) % N]) g = (m_last + k) % N;
            exp_rdy = (g >= 0) ? 4'b0001 << g : 4'b0000;
            chk("rnd_ready", req_ready, exp_rdy);
            chk("rnd_busy", busy, !m_idle);
            chk("rnd_start", cu_start, cyc == g_cyc + 1);
            chk("rnd_jobs", jobs_done, m_jobs);
            if (m_idle) chk("rnd_idle_rsp", rsp_valid, 0);
            if (g >= 0) begin
                e.id = 2'(g); e.data = req_data[g*DW +: DW] << 3;
                q.push_back(e);
                m_last = g; m_idle = 0; g_cyc = cyc;
            end else if (!m_idle && rsp_valid) begin
                chk("rnd_rsp_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    chk("rnd_rsp_id", rsp_id, q[0].id);
                    chk("rnd_rsp_data", rsp_data, q[0].data);
                    chk("rnd_rsp_err", rsp_err, 0);
                    if (rsp_ready) begin void'(q.pop_front()); m_jobs++; m_idle = 1; end
                end
            end
        end
        chk("rnd_progress", m_jobs > 20, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
